// File: rtl/cp0_timer_irq.sv
// cp0_timer_irq: MIPS CP0 with SR/Cause/EPC/PRId/BadVAddr and interrupt arbitration.
// Define CP0_TIMER_EN to build in the Count/Compare timer (regs 9/11, Cause.TI).
module cp0_timer_irq #(
    parameter int unsigned NUM_HWINT  = 6,
    parameter logic [31:0] PRID_VAL   = 32'h2001_1119,
    parameter int unsigned TIMER_LINE = 5,
    parameter int unsigned TIMER_DIV  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_HWINT-1:0] hwint,
    input  logic [4:0]           exc_code,
    input  logic [31:0]          exc_pc,
    input  logic                 exc_bd,
    input  logic [31:0]          exc_badvaddr,
    input  logic                 eret,
    input  logic                 we,
    input  logic [4:0]           waddr,
    input  logic [31:0]          wdata,
    input  logic [4:0]           raddr,
    output logic [31:0]          rdata,
    output logic                 int_req,
    output logic [31:0]          epc_out,
    output logic                 exl_out
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic        ti;
    logic [5:0]  ip_now;
    logic        irq_pend;
    logic        exc_pend;
    logic        wr_ok;
    logic [31:0] epc_base;
    logic [31:0] count_rd;
    logic [31:0] compare_rd;
    logic        unused_bits;

    assign ip_now   = 6'(hwint) | (6'(ti) << TIMER_LINE);
    assign irq_pend = sr_ie & ~sr_exl & (|(sr_im & ip_now));
    assign exc_pend = (exc_code != 5'd0) & ~sr_exl;
    assign int_req  = irq_pend | exc_pend;
    assign wr_ok    = we & ~int_req & ~eret;
    assign epc_base = {exc_pc[31:2], 2'b00};
    assign epc_out  = epc;
    assign exl_out  = sr_exl;
    assign unused_bits = ^exc_pc[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= 6'h3f;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b1;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
            epc       <= 32'd0;
            badvaddr  <= 32'd0;
        end else begin
            cause_ip <= ip_now;
            if (int_req) begin
                epc       <= exc_bd ? epc_base - 32'd4 : epc_base;
                cause_bd  <= exc_bd;
                sr_exl    <= 1'b1;
                cause_exc <= irq_pend ? 5'd0 : exc_code;
                // BadVAddr only tracks address-error exceptions
                if (!irq_pend && (exc_code == 5'd4 || exc_code == 5'd5))
                    badvaddr <= exc_badvaddr;
            end else if (eret) begin
                sr_exl <= 1'b0;
            end else if (wr_ok) begin
                case (waddr)
                    5'd12: begin
                        sr_im  <= wdata[15:10];
                        sr_exl <= wdata[1];
                        sr_ie  <= wdata[0];
                    end
                    5'd14:   epc <= wdata;
                    default: ;
                endcase
            end
        end
    end

`ifdef CP0_TIMER_EN
    localparam int unsigned PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

    logic [PW-1:0] presc;
    logic [31:0]   count;
    logic [31:0]   compare;
    logic          tick;
    logic          count_wr;
    logic          cmp_wr;
    logic          inc;

    assign tick     = (presc == PW'(TIMER_DIV - 1));
    assign count_wr = wr_ok & (waddr == 5'd9);
    assign cmp_wr   = wr_ok & (waddr == 5'd11);
    assign inc      = tick & ~count_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc   <= '0;
            count   <= 32'd0;
            compare <= 32'd0;
            ti      <= 1'b0;
        end else begin
            if (count_wr) begin
                count <= wdata;
                presc <= '0;
            end else begin
                presc <= tick ? '0 : presc + PW'(1);
                if (tick)
                    count <= count + 32'd1;
            end
            if (cmp_wr)
                compare <= wdata;
            // Compare write acknowledges the timer, even against a fresh match
            if (cmp_wr)
                ti <= 1'b0;
            else if (inc && count == compare)
                ti <= 1'b1;
        end
    end

    assign count_rd   = count;
    assign compare_rd = compare;
`else
    logic unused_timer_cfg;

    assign ti               = 1'b0;
    assign count_rd         = 32'd0;
    assign compare_rd       = 32'd0;
    assign unused_timer_cfg = ^TIMER_DIV;
`endif

    always_comb begin
        rdata = 32'd0;
        case (raddr)
            5'd8:    rdata = badvaddr;
            5'd9:    rdata = count_rd;
            5'd11:   rdata = compare_rd;
            5'd12:   rdata = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
            5'd13:   rdata = {cause_bd, ti, 14'd0, cause_ip, 3'd0, cause_exc, 2'd0};
            5'd14:   rdata = epc;
            5'd15:   rdata = PRID_VAL;
            default: rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_timer_irq.sv
// tb_cp0_timer_irq: scoreboard bench for cp0_timer_irq.
// Timer checks follow CP0_TIMER_EN; otherwise regs 9/11 must read 0.
`timescale 1ns/1ps
module tb_cp0_timer_irq;

    localparam logic [31:0] PRID = 32'h2001_1119;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  hwint;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic        int_req;
    logic [31:0] epc_out;
    logic        exl_out;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;
    int   n;

    always #50 clk = ~clk;

    cp0_timer_irq dut (
        .clk(clk),
        .reset(reset),
        .hwint(hwint),
        .exc_code(exc_code),
        .exc_pc(exc_pc),
        .exc_bd(exc_bd),
        .exc_badvaddr(exc_badvaddr),
        .eret(eret),
        .we(we),
        .waddr(waddr),
        .wdata(wdata),
        .raddr(raddr),
        .rdata(rdata),
        .int_req(int_req),
        .epc_out(epc_out),
        .exl_out(exl_out)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic pop(input logic [31:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            n_run++;
            n_fail++;
            $display("FAIL sb_empty: got %h with nothing expected", got);
        end else begin
            e = sb.pop_front();
            check(e.tag, got, e.v);
        end
    endtask

    task automatic cmp(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        push(tag, exp);
        pop(got);
    endtask

    task automatic rd(input string tag, input logic [4:0] a,
                      input logic [31:0] exp);
        push(tag, exp);
        raddr = a;
        #1;
        pop(rdata);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t reached limit %0d", $time, 1_000_000);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; hwint = '0; exc_code = '0; exc_pc = '0;
        exc_bd = 1'b0; exc_badvaddr = '0; eret = 1'b0;
        we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
        step(); step();
        reset = 1'b0;

        rd("rst_sr", 12, 32'h0000_FC01);
        rd("rst_cause", 13, 32'h0);
        rd("rst_epc", 14, 32'h0);
        rd("rst_prid", 15, PRID);
        rd("rst_bad", 8, 32'h0);
        cmp("rst_irq", int_req, 0);
        cmp("rst_exl", exl_out, 0);
        // park Compare far away so the timer stays quiet
        mtc0(11, 32'hFFFF_0000);
        step(); we = 1'b0;

        hwint = 6'b000100; exc_pc = 32'h0000_3008; exc_bd = 1'b1;
        #1 cmp("hw2_req", int_req, 1);
        step(); exc_bd = 1'b0; exc_pc = '0;
        rd("hw2_epc", 14, 32'h0000_3004);
        rd("hw2_cause", 13, 32'h8000_1000);
        cmp("hw2_exl", exl_out, 1);
        cmp("hw2_epc_out", epc_out, 32'h0000_3004);
        cmp("hw2_blk", int_req, 0);
        hwint = '0; eret = 1'b1;
        step(); eret = 1'b0;
        cmp("eret1_exl", exl_out, 0);
        rd("eret1_cause", 13, 32'h8000_0000);

        exc_code = 5'd4; exc_badvaddr = 32'h0000_1001;
        exc_pc = 32'h0000_3010; mtc0(14, 32'hDEAD_BEEF);
        #1 cmp("exc_req", int_req, 1);
        step(); exc_code = '0; exc_badvaddr = '0; exc_pc = '0; we = 1'b0;
        rd("exc_epc", 14, 32'h0000_3010);
        rd("exc_cause", 13, 32'h0000_0010);
        rd("exc_bad", 8, 32'h0000_1001);
        cmp("exc_exl", exl_out, 1);
        exc_code = 5'd5; exc_badvaddr = 32'h0000_0BAD; eret = 1'b1;
        #1 cmp("exl_blk", int_req, 0);
        step(); exc_code = '0; exc_badvaddr = '0; eret = 1'b0;
        cmp("eret2_exl", exl_out, 0);
        rd("blk_bad", 8, 32'h0000_1001);

        mtc0(14, 32'h1234_5678);
        rd("epc_nobyp", 14, 32'h0000_3010);
        step(); we = 1'b0;
        rd("epc_wr", 14, 32'h1234_5678);
        mtc0(15, 32'h0);
        step(); we = 1'b0;
        rd("prid_ro", 15, PRID);
        mtc0(8, 32'hFFFF_FFFF);
        step(); we = 1'b0;
        rd("bad_ro", 8, 32'h0000_1001);

`ifdef CP0_TIMER_EN
        mtc0(11, 32'd5);
        step();
        mtc0(9, 32'd0);
        step(); we = 1'b0;
        n = 0;
        raddr = 13;
        while (n < 20) begin
            #1;
            if (rdata[30]) break;
            step();
            n++;
        end
        cmp("ti_lat", n, 6);
        rd("ti_cnt", 9, 32'd6);
        #1 cmp("ti_req", int_req, 1);
        step();
        rd("ti_cause", 13, 32'h4000_8000);
        cmp("ti_exl", exl_out, 1);
        mtc0(11, 32'd100);
        step(); we = 1'b0;
        raddr = 13;
        #1 cmp("ti_clr", rdata & 32'h4000_0000, 32'h0);
        eret = 1'b1;
        step(); eret = 1'b0;
        mtc0(9, 32'hFFFF_FFFF);
        step(); we = 1'b0;
        rd("cnt_max", 9, 32'hFFFF_FFFF);
        step();
        rd("cnt_wrap", 9, 32'h0);
`else
        mtc0(11, 32'd5);
        step(); we = 1'b0;
        rd("no_cmp", 11, 32'h0);
        mtc0(9, 32'd7);
        step(); we = 1'b0;
        rd("no_cnt", 9, 32'h0);
        rd("no_ti", 13, 32'h0000_0010);
`endif

        mtc0(12, 32'hFFFF_FFFE);
        step(); we = 1'b0;
        rd("sr_mask", 12, 32'h0000_FC02);
        cmp("sr_exl", exl_out, 1);
        mtc0(12, 32'h0000_0400);
        step(); we = 1'b0;
        rd("sr_im0", 12, 32'h0000_0400);
        hwint = 6'b000001;
        #1 cmp("ie0_req", int_req, 0);
        mtc0(12, 32'h0000_0401);
        rd("sr_nobyp", 12, 32'h0000_0400);
        cmp("ie_wr_req", int_req, 0);
        step(); we = 1'b0;
        #1 cmp("ie1_req", int_req, 1);

        reset = 1'b1; hwint = '0;
        step(); reset = 1'b0;
        rd("rst2_sr", 12, 32'h0000_FC01);
        rd("rst2_cause", 13, 32'h0);
        rd("rst2_epc", 14, 32'h0);
        rd("rst2_bad", 8, 32'h0);
        cmp("rst2_exl", exl_out, 0);
        cmp("rst2_irq", int_req, 0);
`ifdef CP0_TIMER_EN
        rd("rst2_cnt", 9, 32'h0);
        rd("rst2_cmp", 11, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_timer_irq.md
Name: cp0_timer_irq

Overview:
- Parametrised next-generation system-control coprocessor (CP0) for the pipelined MIPS core.
- Sits beside the memory stage and holds SR, Cause, EPC, PRId, BadVAddr and an optional Count/Compare timer.
- Arbitrates between external interrupts, the timer interrupt and synchronous exceptions, then drives the PC-redirect request.
- Generalises the earlier CP0 with a configurable interrupt line count, BadVAddr capture, an explicit eret path and a write-protected register map.

Parameters:
NUM_HWINT, 6, number of external interrupt lines (1..6); line i maps to Cause.IP[10+i] and SR.IM[10+i]
PRID_VAL, 32'h2001_1119, read-only PRId contents
TIMER_LINE, 5, IP/IM bit index (0..5) onto which the timer interrupt is ORed
TIMER_DIV, 1, Count increments once every TIMER_DIV cycles (1..256)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
hwint  in  NUM_HWINT  external interrupt levels
exc_code  in  5  exception code from the pipeline; 0 = no exception
exc_pc  in  32  PC of the faulting or interrupted instruction
exc_bd  in  1  instruction sits in a branch delay slot
exc_badvaddr  in  32  faulting address, valid with exc_code 4/5
eret  in  1  eret instruction committing this cycle
we  in  1  mtc0 write strobe
waddr  in  5  mtc0 register number
wdata  in  32  mtc0 data
raddr  in  5  mfc0 register number
rdata  out  32  combinational read data
int_req  out  1  redirect the PC to the handler this cycle
epc_out  out  32  current EPC, used by eret
exl_out  out  1  current SR.EXL

Behaviour:
- Register map: 8 = BadVAddr (read-only), 9 = Count, 11 = Compare, 12 = SR, 13 = Cause (read-only), 14 = EPC, 15 = PRId (read-only). Any other raddr reads 0.
- SR layout: IM at [15:10], EXL at [1], IE at [0]. All other bits read 0 and ignore writes.
- Cause layout: BD at [31], TI at [30], IP at [15:10], ExcCode at [6:2].
- Reset values: SR = {IM = all ones, EXL = 0, IE = 1}; Cause = 0; EPC = 0; BadVAddr = 0; Count = 0; Compare = 0. Consequently int_req = 0, rdata = SR when raddr = 12, and exl_out = 0.
- Cause.IP is resampled every non-reset cycle as {hwint, zero-extended} OR (TI << TIMER_LINE). Unused IP bits stay 0.
- irq_pend = IE & ~EXL & |(IM & IP), evaluated combinationally on the current hwint and TI.
- exc_pend = (exc_code != 0) & ~EXL.
- int_req = irq_pend | exc_pend.
- Priority within one cycle: reset > interrupt > exception > eret > mtc0 write.
- Interrupt or exception accept, registered on the next edge:
  - EPC = {exc_pc[31:2], 2'b00}, minus 4 when exc_bd = 1.
  - BD = exc_bd; EXL = 1.
  - ExcCode = 0 for an interrupt, exc_code otherwise.
  - BadVAddr is loaded only for an exception with exc_code 4 or 5.
  - A concurrent we or eret is dropped.
- With EXL = 1, exceptions are not accepted and int_req = 0.
- eret (no accept pending): EXL cleared on the next edge; EPC unchanged.
- mtc0: writes SR (masked bits only), EPC, Count or Compare. Writes to read-only or unmapped registers are silently ignored.
- rdata has no write bypass; it shows the pre-edge value in a write cycle.
- Timer:
  - A prescaler counts 0..TIMER_DIV-1; Count increments when the prescaler wraps, and wraps 32'hFFFF_FFFF -> 0.
  - A Count write has priority over the increment in the same cycle and resets the prescaler.
  - When registered Count == Compare and Count incremented this cycle, TI sets on the next edge.
  - TI is sticky until Compare is written. A Compare write in the same cycle as a match leaves TI = 0.

Optional Feature:
- Macro CP0_TIMER_EN.
- Defined: the Count/Compare/TI logic above is present.
- Undefined: no timer logic is instantiated. Registers 9 and 11 read 0 and ignore writes, TI is constant 0, and TIMER_LINE and TIMER_DIV are unused.

Test Plan:
- Reset, then read regs 12/13/14/15 -> 32'h0000_FC01, 0, 0, PRID_VAL; int_req = 0.
- hwint[2] = 1 with exc_pc = 32'h0000_3008, exc_bd = 1 -> int_req = 1 that cycle; next cycle EPC = 32'h0000_3004, Cause = 32'h8000_1000, EXL = 1, int_req = 0.
- exc_code = 4, exc_badvaddr = 32'h0000_1001, exc_pc = 32'h3010, concurrent we to EPC -> EPC = 32'h3010, ExcCode = 4, BadVAddr = 32'h1001, write dropped. eret next cycle -> EXL = 0.
- mtc0 SR = 32'h0000_0400 (IM0 only, IE = 0) then raise hwint[0] -> no int_req. Write SR = 32'h0000_0401 -> int_req asserts in the same cycle as the write edge completes.
- CP0_TIMER_EN, TIMER_DIV = 1, Compare = 5, Count = 0 -> TI set once Count reaches 5; int_req on line TIMER_LINE. Compare write -> TI = 0. Without the macro, reg 11 reads 0 after a write.
- Count written to 32'hFFFF_FFFF -> reads 0 after one increment; reset asserted mid-interrupt -> all registers back to reset values next edge.
